// File: rtl/sync_gather.sv
// Multi-channel frame aligner: gathers one sample per channel into a single
// ready/valid bundle, with overrun policy, optional partial-bundle timeout and backpressure.
module sync_gather #(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 0,
   parameter int OVERWRITE = 1
) (
   input  logic                     clk_pixel_in,
   input  logic                     rst_n_in,
   input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
   input  logic [NUM_CH-1:0]        ch_valid_in,
   input  logic                     out_ready_in,
   output logic [NUM_CH*DATA_W-1:0] bundle_out,
   output logic [NUM_CH-1:0]        bundle_mask_out,
   output logic                     bundle_valid_out,
   output logic                     timeout_out,
   output logic [15:0]              overrun_count_out
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit HAS_TO = (TIMEOUT > 0);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [NUM_CH-1:0]         got_q, got_d;
   logic [NUM_CH*DATA_W-1:0]  cap_q, cap_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic                      pend_to_q, pend_to_d;
   logic [NUM_CH*DATA_W-1:0]  bundle_q, bundle_d;
   logic [NUM_CH-1:0]         mask_q, mask_d;
   logic                      valid_q, valid_d;
   logic                      to_q, to_d;
   logic [15:0]               ovr_q, ovr_d;

   logic                      slot_free_s;
   logic [NUM_CH-1:0]         got_next_s;
   logic [NUM_CH*DATA_W-1:0]  merged_s;
   logic [NUM_CH*DATA_W-1:0]  launch_data_s;
   logic                      launch_req_s;
   logic                      force_to_s;
   logic                      hit_s;
   logic [16:0]               ovr_sum_s;

   function automatic logic [15:0] count_ones(input logic [NUM_CH-1:0] v);
      logic [15:0] c;
      c = 16'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = c + {15'd0, v[i]};
      end
      return c;
   endfunction

   assign slot_free_s = !valid_q || out_ready_in;
   assign got_next_s  = got_q | ch_valid_in;
   assign hit_s       = HAS_TO && (timer_q == T_LAST);

   // Sample merge: a repeat only replaces the stored sample when OVERWRITE is set
   always_comb begin
      merged_s      = cap_q;
      launch_data_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_valid_in[i] && (!got_q[i] || (OVERWRITE != 0))) begin
            merged_s[i*DATA_W +: DATA_W] = ch_data_in[i*DATA_W +: DATA_W];
         end else begin
            merged_s[i*DATA_W +: DATA_W] = cap_q[i*DATA_W +: DATA_W];
         end
         if (got_next_s[i]) begin
            launch_data_s[i*DATA_W +: DATA_W] = merged_s[i*DATA_W +: DATA_W];
         end else begin
            launch_data_s[i*DATA_W +: DATA_W] = '0;
         end
      end
   end

   // Next-state, capture and output-register logic
   always_comb begin
      state_d      = state_q;
      got_d        = got_next_s;
      cap_d        = merged_s;
      timer_d      = timer_q;
      pend_to_d    = pend_to_q;
      bundle_d     = bundle_q;
      mask_d       = mask_q;
      valid_d      = valid_q;
      to_d         = to_q;
      launch_req_s = 1'b0;
      force_to_s   = 1'b0;
      ovr_sum_s    = {1'b0, ovr_q} + {1'b0, count_ones(ch_valid_in & got_q)};
      ovr_d        = ovr_sum_s[16] ? 16'hFFFF : ovr_sum_s[15:0];

      case (state_q)
         ST_IDLE: begin
            if (&got_next_s) begin
               launch_req_s = 1'b1;
            end else if (|ch_valid_in) begin
               state_d = ST_COLLECT;
               timer_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (&got_next_s) begin
               launch_req_s = 1'b1;
            end else if (hit_s) begin
               launch_req_s = 1'b1;
               force_to_s   = 1'b1;
            end else if (HAS_TO && (timer_q != T_LAST)) begin
               timer_d = timer_q + TW'(1);
            end else begin
               timer_d = timer_q;
            end
         end
         ST_PENDING: begin
            launch_req_s = 1'b1;
            force_to_s   = pend_to_q;
         end
         default: begin
            state_d = ST_IDLE;
            got_d   = '0;
            cap_d   = '0;
         end
      endcase

      if (launch_req_s && slot_free_s) begin
         bundle_d  = launch_data_s;
         mask_d    = got_next_s;
         valid_d   = 1'b1;
         to_d      = force_to_s;
         got_d     = '0;
         cap_d     = '0;
         timer_d   = '0;
         pend_to_d = 1'b0;
         state_d   = ST_IDLE;
      end else begin
         if (valid_q && out_ready_in) begin
            valid_d = 1'b0;
            to_d    = 1'b0;
         end else begin
            valid_d = valid_q;
            to_d    = to_q;
         end
         if (launch_req_s) begin
            state_d   = ST_PENDING;
            pend_to_d = force_to_s;
         end else begin
            pend_to_d = pend_to_q;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         got_q     <= '0;
         cap_q     <= '0;
         timer_q   <= '0;
         pend_to_q <= 1'b0;
         bundle_q  <= '0;
         mask_q    <= '0;
         valid_q   <= 1'b0;
         to_q      <= 1'b0;
         ovr_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         got_q     <= got_d;
         cap_q     <= cap_d;
         timer_q   <= timer_d;
         pend_to_q <= pend_to_d;
         bundle_q  <= bundle_d;
         mask_q    <= mask_d;
         valid_q   <= valid_d;
         to_q      <= to_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bundle_out        = bundle_q;
   assign bundle_mask_out   = mask_q;
   assign bundle_valid_out  = valid_q;
   assign timeout_out       = to_q;
   assign overrun_count_out = ovr_q;

endmodule
